// File: rtl/sm_pkg.sv
// Shared encodings for the instruction-sequencing controller: FSM states,
// opcode classes, ALU operations and writeback source selects.
package sm_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WBACK  = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/sm_idec.sv
// Instruction register field extraction, 8-bit immediate sign extension and
// instruction-class decode. Purely combinational.
module sm_idec
    import sm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] ir,
    output logic [1:0]       op,
    output logic [2:0]       rn,
    output logic [2:0]       rd,
    output logic [1:0]       sh,
    output logic [2:0]       rm,
    output logic [WIDTH-1:0] sximm8,
    output logic             is_mov_imm,
    output logic             is_mov_reg,
    output logic             is_alu,
    output logic             is_mvn,
    output logic             is_cmp
);

    logic [2:0] opcode;

    always_comb begin
        opcode = ir[15:13];
        op     = ir[12:11];
        rn     = ir[10:8];
        rd     = ir[7:5];
        sh     = ir[4:3];
        rm     = ir[2:0];
        sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

        is_mov_imm = (opcode == OPC_MOV) && (op == MOV_IMM);
        is_mov_reg = (opcode == OPC_MOV) && (op == MOV_REG);
        is_alu     = (opcode == OPC_ALU);
        is_mvn     = is_alu && (op == ALU_MVN);
        is_cmp     = is_alu && (op == ALU_CMP);
    end

endmodule

// File: rtl/sm_controller.sv
// Control FSM and instruction register: sequences register file, shifter,
// ALU and A/B/C/status registers for one instruction per start pulse.
module sm_controller
    import sm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic             w,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [WIDTH-1:0] sximm8
);

    state_t           state;
    logic [WIDTH-1:0] ir;

    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_mvn;
    logic       is_cmp;

    sm_idec #(
        .WIDTH(WIDTH)
    ) u_idec (
        .ir        (ir),
        .op        (op),
        .rn        (rn),
        .rd        (rd),
        .sh        (sh),
        .rm        (rm),
        .sximm8    (sximm8),
        .is_mov_imm(is_mov_imm),
        .is_mov_reg(is_mov_reg),
        .is_alu    (is_alu),
        .is_mvn    (is_mvn),
        .is_cmp    (is_cmp)
    );

    // IR only accepts a new word while idle so an executing instruction is stable.
    always_ff @(posedge clk) begin
        if (reset)
            ir <= '0;
        else if (load && state == S_WAIT)
            ir <= in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            case (state)
                S_WAIT:   state <= s ? S_DECODE : S_WAIT;
                S_DECODE: begin
                    if (is_mov_imm)
                        state <= S_WIMM;
                    else if (is_mov_reg || is_mvn)
                        state <= S_GET_B;
                    else if (is_alu)
                        state <= S_GET_A;
                    else
                        state <= S_WAIT;
                end
                S_WIMM:   state <= S_WAIT;
                S_GET_A:  state <= S_GET_B;
                S_GET_B:  state <= S_EXEC;
                S_EXEC:   state <= is_cmp ? S_WAIT : S_WBACK;
                S_WBACK:  state <= S_WAIT;
                default:  state <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        case (state)
            S_WAIT:  w = 1'b1;
            S_WIMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                ALUop = is_mov_reg ? ALU_ADD : op;
                asel  = is_mov_reg || is_mvn;
                if (is_cmp)
                    loads = 1'b1;
                else
                    loadc = 1'b1;
            end
            S_WBACK: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sm_controller.sv
// Directed table-driven bench for sm_controller plus latency/write-count sequences.
module tb_sm_controller;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    sm_controller #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada, loadb, loadc, loads;
        logic       asel, bsel;
        logic [1:0] vsel, shift, aluop;
    } ctl_t;

    typedef struct {
        logic        rst, s, ld;
        logic [15:0] in;
        ctl_t        exp;
        logic [15:0] imm;
    } vec_t;

    vec_t tv[$];

    function automatic ctl_t mk(logic w_, logic [2:0] rn_, logic [2:0] wn_, logic wr_,
                                logic la_, logic lb_, logic lc_, logic ls_, logic as_,
                                logic [1:0] vs_, logic [1:0] sh_, logic [1:0] op_);
        ctl_t c;
        c = '{w: w_, readnum: rn_, writenum: wn_, write: wr_, loada: la_, loadb: lb_,
              loadc: lc_, loads: ls_, asel: as_, bsel: 1'b0, vsel: vs_, shift: sh_, aluop: op_};
        return c;
    endfunction

    function automatic ctl_t actual();
        ctl_t c;
        c = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop};
        return c;
    endfunction

    task automatic addv(logic r, logic s_, logic l, logic [15:0] i, ctl_t e, logic [15:0] im);
        vec_t v;
        v.rst = r; v.s = s_; v.ld = l; v.in = i; v.exp = e; v.imm = im;
        tv.push_back(v);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Start one instruction, count w=0 cycles and write pulses until idle again.
    task automatic run_latency(string name, logic [15:0] instr, int exp_lat, int exp_wr);
        int lat = 0;
        int wr = 0;
        reset = 1'b0; s = 1'b1; load = 1'b1; in = instr;
        @(posedge clk); #1;
        s = 1'b0; load = 1'b0;
        while (w == 1'b0 && lat < 20) begin
            lat++;
            if (write) wr++;
            @(posedge clk); #1;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " writes"}, wr, exp_wr);
    endtask

    initial begin
        ctl_t IDLE, NONE;
        IDLE = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        NONE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        addv(1, 0, 0, 16'h0000, IDLE, 16'h0000);
        // MOV R0,#7
        addv(0, 1, 1, 16'hD007, NONE, 16'h0007);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00), 16'h0007);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0007);
        // MOV R1,#-2 with load pulses outside WAIT
        addv(0, 1, 1, 16'hD1FE, NONE, 16'hFFFE);
        addv(0, 0, 1, 16'h0000, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00), 16'hFFFE);
        addv(0, 0, 1, 16'h0000, IDLE, 16'hFFFE);
        addv(0, 0, 0, 16'h0000, IDLE, 16'hFFFE);
        // ADD R2,R1,R0 LSL#1
        addv(0, 1, 1, 16'hA148, NONE, 16'h0048);
        addv(0, 0, 0, 16'h0000, mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00), 16'h0048);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0048);
        // CMP R1,R0
        addv(0, 1, 1, 16'hA900, NONE, 16'h0000);
        addv(0, 0, 0, 16'h0000, mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0000);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0000);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01), 16'h0000);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0000);
        // MVN R3,R0
        addv(0, 1, 1, 16'hB860, NONE, 16'h0060);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0060);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b11), 16'h0060);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0060);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0060);
        // MOV R5,R1 LSR: 0xC0B1
        addv(0, 1, 1, 16'hC0B1, NONE, 16'hFFB1);
        addv(0, 0, 0, 16'h0000, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'hFFB1);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b10, 2'b00), 16'hFFB1);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'hFFB1);
        addv(0, 0, 0, 16'h0000, IDLE, 16'hFFB1);
        // Illegal opcode and illegal MOV sub-op
        addv(0, 1, 1, 16'hE000, NONE, 16'h0000);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0000);
        addv(0, 1, 1, 16'hC812, NONE, 16'h0012);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0012);
        // Reset during GET_B of ADD; s and load ignored while reset is high
        addv(0, 1, 1, 16'hA148, NONE, 16'h0048);
        addv(0, 0, 0, 16'h0000, mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
        addv(0, 0, 0, 16'h0000, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), 16'h0048);
        addv(1, 1, 0, 16'h0000, IDLE, 16'h0000);
        addv(1, 1, 1, 16'hD007, IDLE, 16'h0000);
        addv(0, 0, 0, 16'h0000, IDLE, 16'h0000);

        reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;
        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst; s = tv[i].s; load = tv[i].ld; in = tv[i].in;
            @(posedge clk); #1;
            check($sformatf("vec%0d ctl", i), 32'(actual()), 32'(tv[i].exp));
            check($sformatf("vec%0d sximm8", i), 32'(sximm8), 32'(tv[i].imm));
        end

        run_latency("MOV imm", 16'hD3FF, 2, 1);
        run_latency("MOV reg", 16'hC0A9, 4, 1);
        run_latency("MVN",     16'hB8E1, 4, 1);
        run_latency("CMP",     16'hAA02, 4, 0);
        run_latency("ADD",     16'hA148, 5, 1);
        run_latency("AND",     16'hB064, 5, 1);
        run_latency("illegal", 16'h2000, 1, 0);

        // s low in WAIT must keep the controller idle
        reset = 1'b0; s = 1'b0; load = 1'b1; in = 16'hA148;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold idle w", 32'(w), 32'd1);
        end
        check("hold idle imm", 32'(sximm8), 32'h0000_0048);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_controller.md
Name: sm_controller

Overview:
- Control FSM plus instruction register (IR) that sequences the existing 8x16 register file, shifter, ALU and A/B/C/status registers.
- Executes one 16-bit instruction per start pulse: MOV immediate, MOV register with shift, ADD, CMP, AND, MVN.
- Drives every datapath load enable, read/write register number and mux select.
- Reports idle to the testbench/top level through w.

Parameters:
- WIDTH, 16, instruction and immediate width (fixed at 16; not meant to be changed)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears state and IR
- s  in  1  start; sampled only in WAIT
- load  in  1  IR load enable; honoured only in WAIT
- in  in  16  instruction word
- w  out  1  1 when in WAIT (idle)
- readnum  out  3  regfile read select
- writenum  out  3  regfile write select
- write  out  1  regfile write enable
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand from sximm5 (always 0 here)
- vsel  out  2  writeback source: 00 = C, 10 = sximm8
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm8  out  16  sign-extended IR[7:0], continuous

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Reset: at a clk edge with reset=1, state <= WAIT and IR <= 0. Reset overrides s and load. Reset mid-instruction aborts it; no further write or load is issued.
- Outputs are a combinational (Moore) function of state and IR. Defaults in every state: all enables 0, readnum = writenum = 0, asel = bsel = 0, vsel = 00, shift = 00, ALUop = 00.
- IR update: IR <= in when load=1 and state = WAIT. If load and s are both 1 in the same WAIT cycle, DECODE sees the new IR.
- WAIT: w=1. s=1 -> DECODE; otherwise stay.
- DECODE: no enables asserted. Next state:
  - 110/10 -> WIMM
  - 110/00 -> GET_B
  - 101/11 (MVN) -> GET_B
  - 101/other -> GET_A
  - anything else (illegal) -> WAIT
- WIMM: writenum = Rn, vsel = 10, write = 1 -> WAIT.
- GET_A: readnum = Rn, loada = 1 -> GET_B.
- GET_B: readnum = Rm, loadb = 1 -> EXEC.
- EXEC: shift = sh, bsel = 0.
  - ALUop = op for opcode 101; 00 for MOV register.
  - asel = 1 for MOV register and MVN.
  - CMP: loads = 1, loadc = 0 -> WAIT.
  - All others: loadc = 1 -> WBACK.
- WBACK: writenum = Rd, vsel = 00, write = 1 -> WAIT.
- Latency, counted as cycles with w=0 after the s-sampling edge:
  - MOV immediate: 2
  - MOV register, MVN: 4
  - CMP: 4
  - ADD, AND: 5
- write is asserted for exactly one cycle per writing instruction. CMP and illegal instructions never assert write.
- States use a 3-bit encoding. Unused encodings go to WAIT on the next edge.

Decomposition:
- Package sm_pkg holds:
  - state encodings (WAIT, DECODE, WIMM, GET_A, GET_B, EXEC, WBACK)
  - opcode constants OPC_MOV = 3'b110, OPC_ALU = 3'b101
  - ALU op constants ADD = 00, CMP = 01, AND = 10, MVN = 11
  - vsel constants VSEL_C = 2'b00, VSEL_IMM = 2'b10
- Sub-module sm_idec: combinational IR field extraction, sign extension and instruction-class decode.
- The FSM and output logic stay in sm_controller. The IR uses the team's existing load-enable register.

Test Plan:
- MOV R0,#7: in=0xD007, load=1 and s=1 in one WAIT cycle -> DECODE, then WIMM with writenum=0, vsel=10, write=1, sximm8=0x0007; w=1 two cycles later.
- MOV R1,#-2: in=0xD1FE -> sximm8=0xFFFE, writenum=1, single write pulse. Also pulse load=1 with in=0x0000 during WIMM -> IR unchanged (still 0xD1FE).
- ADD R2,R1,R0 LSL#1: in=0xA148 -> GET_A (readnum=1, loada), GET_B (readnum=0, loadb), EXEC (shift=01, ALUop=00, loadc), WBACK (writenum=2, write); w=0 for 5 cycles.
- CMP R1,R0: in=0xA900 -> EXEC with loads=1 and loadc=0, then WAIT; write never asserted. MVN R3,R0: in=0xB860 -> GET_A skipped, EXEC asel=1 and ALUop=11, WBACK writenum=3.
- Illegal 0xE000 -> DECODE then WAIT; no enable asserted in either cycle.
- Reset during GET_B of 0xA148 -> next state WAIT, IR=0x0000, w=1, write never asserted; s=1 held while reset=1 is ignored.
